// File: rtl/dct_input_buffer_if.sv
// Sample stream interface feeding dct_input_buffer.
//   din        : one IEEE-754 single-precision sample (W bits)
//   din_valid  : source has a sample on din this cycle
//   din_ready  : buffer can take the sample this cycle
// Handshake: a beat transfers on a rising clock edge where din_valid and
// din_ready are both high; din_ready never depends on din_valid, and the
// source may change din/din_valid freely in cycles where no beat transfers.
interface dct_input_buffer_if #(
  parameter int W = 32
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/dct_input_buffer.sv
// Ping-pong frame buffer in front of cordic_controller. Samples arrive on the
// stream interface and are packed DCT_POINT at a time into one of two banks.
// A full bank is presented on frame with en held high until the controller
// pulses F; the bank is then freed and, after a GAP_CYCLES en-low gap, the
// other bank (if full) is presented.
// Ports:
//   clk         : clock, rising edge
//   clr         : asynchronous active-low reset
//   s           : sample stream (din / din_valid / din_ready)
//   flush       : synchronous, drops the partially filled bank
//   frame       : contents of the read bank, sample n at [W*n +: W]
//   en          : frame valid to the controller, held until F
//   F           : controller done pulse, only honoured while running
//   busy        : read side is in RUN or GAP
//   frames_done : completed frame count, wraps
//   state_dbg   : read FSM state (0 IDLE, 1 RUN, 2 GAP)
module dct_input_buffer #(
  parameter int M          = 23,
  parameter int E          = 8,
  parameter int DCT_POINT  = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            clr,
  dct_input_buffer_if.slave               s,
  input  logic                            flush,
  output logic [(M+E+1)*DCT_POINT-1:0]    frame,
  output logic                            en,
  input  logic                            F,
  output logic                            busy,
  output logic [15:0]                     frames_done,
  output logic [1:0]                      state_dbg
);
  localparam int W     = M + E + 1;
  localparam int CNT_W = $clog2(DCT_POINT);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [1:0]         bank_full_q, bank_full_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               en_q, en_d;
  logic [15:0]        frames_done_q, frames_done_d;
  logic               din_ready;
  logic               wr_en;

  // Sample storage; deliberately not reset.
  logic [W-1:0]       mem_q [2][DCT_POINT];

  assign din_ready   = !bank_full_q[wr_bank_q] && !flush;
  assign s.din_ready = din_ready;

  always_comb begin
    wr_cnt_d      = wr_cnt_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    bank_full_d   = bank_full_q;
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    en_d          = en_q;
    frames_done_d = frames_done_q;
    wr_en         = 1'b0;

    // Write side. din_ready already folds in flush, so a flushed beat is
    // never written and can never complete a bank.
    if (flush) begin
      wr_cnt_d = '0;
    end else if (s.din_valid && din_ready) begin
      wr_en = 1'b1;
      if (wr_cnt_q == CNT_W'(DCT_POINT - 1)) begin
        wr_cnt_d               = '0;
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = !wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end

    // Read side. IDLE looks at the registered full flags, so a bank that
    // completes this cycle is only seen on the next one. The bank cleared
    // below is the one being read, which is full and therefore never the
    // bank the write side sets in the same cycle.
    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (bank_full_q[rd_bank_q]) begin
          en_d    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (F) begin
          en_d                   = 1'b0;
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = !rd_bank_q;
          frames_done_d          = frames_done_q + 16'd1;
          gap_cnt_d              = GAP_W'(GAP_CYCLES - 1);
          state_d                = GAP;
        end
      end
      GAP: begin
        en_d = 1'b0;
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q       <= IDLE;
      wr_cnt_q      <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      bank_full_q   <= 2'b00;
      gap_cnt_q     <= '0;
      en_q          <= 1'b0;
      frames_done_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      bank_full_q   <= bank_full_d;
      gap_cnt_q     <= gap_cnt_d;
      en_q          <= en_d;
      frames_done_q <= frames_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_cnt_q] <= s.din;
    end
  end

  always_comb begin
    frame = '0;
    for (int n = 0; n < DCT_POINT; n++) begin
      frame[W*n +: W] = mem_q[rd_bank_q][n];
    end
  end

  assign en          = en_q;
  assign busy        = (state_q != IDLE);
  assign frames_done = frames_done_q;
  assign state_dbg   = state_q;
endmodule
